acc_stream_arbiter: RTL

ACC_STREAM_ARBITER -- requirements
Module: acc_stream_arbiter

---
 rtl/acc_stream_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/acc_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : acc_stream_arbiter
// Description : Round-robin, packet-locked merge of MAX_ACCS AXI-Stream
//               accelerator sources onto one tagged output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_stream_arbiter #(
    parameter int MAX_ACCS = 16,
    parameter int ID_W     = $clog2(MAX_ACCS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [MAX_ACCS-1:0]      acc_in_tvalid,
    output logic [MAX_ACCS-1:0]      acc_in_tready,
    input  logic [64*MAX_ACCS-1:0]   acc_in_tdata,
    input  logic [MAX_ACCS-1:0]      acc_in_tlast,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [ID_W-1:0]          out_tid,
    output logic [63:0]              out_tdata,
    output logic                     out_tlast
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            out_tvalid_q;
    logic            out_tlast_q;
    logic [ID_W-1:0] out_tid_q;
    logic [63:0]     out_tdata_q;

    logic            sel_found;
    logic [ID_W-1:0] sel_idx;
    logic [63:0]     gnt_data;
    logic            gnt_valid;
    logic            gnt_last;
    logic            out_free;
    logic            accept;

    // Rotating priority search starting at rr_ptr, wrapping at MAX_ACCS.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < MAX_ACCS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= MAX_ACCS) begin
                idx = idx - MAX_ACCS;
            end
            if (!sel_found && acc_in_tvalid[idx[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_data  = '0;
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        for (int i = 0; i < MAX_ACCS; i++) begin
            if (grant_q == ID_W'(i)) begin
                gnt_data  = acc_in_tdata[64*i +: 64];
                gnt_valid = acc_in_tvalid[i];
                gnt_last  = acc_in_tlast[i];
            end
        end
    end

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = !out_tvalid_q || out_tready;
    assign accept   = (state_q == LOCKED) && gnt_valid && out_free;

    always_comb begin
        acc_in_tready = '0;
        if (state_q == LOCKED && out_free) begin
            acc_in_tready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && gnt_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == ID_W'(MAX_ACCS-1)) ? '0 : grant_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
            out_tid_q    <= '0;
            out_tdata_q  <= '0;
        end else if (accept) begin
            out_tvalid_q <= 1'b1;
            out_tlast_q  <= gnt_last;
            out_tid_q    <= grant_q;
            out_tdata_q  <= gnt_data;
        end else if (out_tready) begin
            out_tvalid_q <= 1'b0;
        end
    end

    assign out_tvalid = out_tvalid_q;
    assign out_tlast  = out_tlast_q;
    assign out_tid    = out_tid_q;
    assign out_tdata  = out_tdata_q;

endmodule
`default_nettype wire
